// File: rtl/dmc_dma_ctrl.sv
// ---------------------------------------------------------------------------
// dmc_dma_ctrl
//
// Delta-modulation channel DMA controller for the APU. It holds the DMC
// sample address/length state and the one-byte sample buffer that feeds the
// DMC output unit. Whenever the buffer is empty and sample bytes remain, it
// steals the CPU bus for a single-byte DMA read:
//
//   IDLE -> HALT -> ALIGN -> FETCH -> IDLE
//
// HALT waits for a CPU read cycle, because the CPU ignores RDY on writes.
// ALIGN is one dummy cycle. FETCH puts DMC_Addr on the bus and latches DB at
// the closing edge.
//
// Ports
//   ACLK        clock, one rising edge per CPU cycle
//   RES         synchronous active-high reset
//   W4010       write strobe $4010 (bit7 irq_en, bit6 loop)
//   W4012       write strobe $4012 (sample start address A)
//   W4013       write strobe $4013 (sample length L)
//   W4015       write strobe $4015 (bit4 channel enable)
//   DB[7:0]     CPU data bus: register write data and DMA read data
//   RnW         CPU cycle type, 1 = read
//   PCM_Take    output unit consumed the buffer (one-cycle pulse)
//   RUNDMC      DMA in progress, holds sprite DMA in standby
//   n_DMCAB     0 = DMC owns the address bus this cycle
//   DMCRDY      0 = stall the CPU
//   DMC_Addr    sample address counter
//   PCM_Buf     sample buffer
//   PCM_Empty   sample buffer empty
//   DMC_Active  bytes remaining != 0
//   DMC_INT     DMC interrupt flag
// ---------------------------------------------------------------------------
module dmc_dma_ctrl (
  input  logic        ACLK,
  input  logic        RES,
  input  logic        W4010,
  input  logic        W4012,
  input  logic        W4013,
  input  logic        W4015,
  input  logic [7:0]  DB,
  input  logic        RnW,
  input  logic        PCM_Take,
  output logic        RUNDMC,
  output logic        n_DMCAB,
  output logic        DMCRDY,
  output logic [15:0] DMC_Addr,
  output logic [7:0]  PCM_Buf,
  output logic        PCM_Empty,
  output logic        DMC_Active,
  output logic        DMC_INT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HALT  = 2'd1,
    ST_ALIGN = 2'd2,
    ST_FETCH = 2'd3
  } state_e;

  state_e      state_q, state_d;

  logic        irq_en_q, irq_en_d;
  logic        loop_q, loop_d;
  logic [7:0]  smp_addr_q, smp_addr_d;
  logic [7:0]  smp_len_q, smp_len_d;
  logic [11:0] remaining_q, remaining_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  pcm_buf_q, pcm_buf_d;
  logic        pcm_empty_q, pcm_empty_d;
  logic        dmc_int_q, dmc_int_d;

  logic        fetch_edge;
  logic        disable_wr;
  logic        enable_wr;
  logic        sample_end;
  logic        loop_reload;
  logic [15:0] start_addr;
  logic [11:0] start_len;
  logic [15:0] addr_inc;

  // Sample start point and length derived from the programmed A and L:
  // address = $C000 + A*64, length = L*16 + 1.
  assign start_addr = {2'b11, smp_addr_q, 6'b000000};
  assign start_len  = {smp_len_q, 4'b0001};

  // The counter lives in the upper half of memory, so $FFFF rolls to $8000.
  assign addr_inc = (addr_q == 16'hFFFF) ? 16'h8000 : (addr_q + 16'd1);

  assign fetch_edge = (state_q == ST_FETCH);
  assign disable_wr = W4015 & ~DB[4];
  assign enable_wr  = W4015 & DB[4];

  // A sample ends when the fetch consumes its last byte. A disable written
  // during a DMA has already forced remaining to zero, so it never reaches 1.
  assign sample_end  = fetch_edge && (remaining_q == 12'd1);
  assign loop_reload = sample_end & loop_q & ~disable_wr;

  // Next-state logic of the DMA sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pcm_empty_q && (remaining_q != 12'd0)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // The CPU only honours RDY on read cycles, so keep waiting through
        // any write cycles.
        if (RnW) begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: state_d = ST_FETCH;
      ST_FETCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Programmable registers. New values only take effect at the next reload,
  // so writing A or L never disturbs a sample in progress.
  always_comb begin
    irq_en_d   = irq_en_q;
    loop_d     = loop_q;
    smp_addr_d = smp_addr_q;
    smp_len_d  = smp_len_q;
    if (W4010) begin
      irq_en_d = DB[7];
      loop_d   = DB[6];
    end
    if (W4012) begin
      smp_addr_d = DB;
    end
    if (W4013) begin
      smp_len_d = DB;
    end
  end

  // Address counter and remaining-byte counter.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;

    if (fetch_edge) begin
      addr_d = addr_inc;
      // A disable during HALT/ALIGN leaves remaining at zero; the byte is
      // still delivered but the counter must not underflow.
      if (remaining_q != 12'd0) begin
        remaining_d = remaining_q - 12'd1;
      end
    end

    if (loop_reload) begin
      addr_d      = start_addr;
      remaining_d = start_len;
    end

    // $4015 is evaluated against the post-fetch count so that an enable
    // landing on the edge that ends a sample restarts it.
    if (disable_wr) begin
      remaining_d = 12'd0;
    end else if (enable_wr && (remaining_d == 12'd0)) begin
      addr_d      = start_addr;
      remaining_d = start_len;
    end
  end

  // Sample buffer. FETCH always finds the buffer empty, so a PCM_Take in
  // that cycle has nothing to consume and the fetched byte takes priority.
  always_comb begin
    pcm_buf_d   = pcm_buf_q;
    pcm_empty_d = pcm_empty_q;
    if (fetch_edge) begin
      pcm_buf_d   = DB;
      pcm_empty_d = 1'b0;
    end else if (PCM_Take) begin
      pcm_empty_d = 1'b1;
    end
  end

  // Interrupt flag: raised at a non-looping sample end with irq_en set.
  // Any $4015 write clears it, which also covers an enable or disable
  // colliding with the final fetch.
  always_comb begin
    dmc_int_d = dmc_int_q;
    if (sample_end && !loop_q && irq_en_q) begin
      dmc_int_d = 1'b1;
    end
    if (W4015 || (W4010 && !DB[7])) begin
      dmc_int_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (RES) begin
      state_q     <= ST_IDLE;
      irq_en_q    <= 1'b0;
      loop_q      <= 1'b0;
      smp_addr_q  <= 8'h00;
      smp_len_q   <= 8'h00;
      remaining_q <= 12'd0;
      addr_q      <= 16'hC000;
      pcm_buf_q   <= 8'h00;
      pcm_empty_q <= 1'b1;
      dmc_int_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_en_q    <= irq_en_d;
      loop_q      <= loop_d;
      smp_addr_q  <= smp_addr_d;
      smp_len_q   <= smp_len_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      pcm_buf_q   <= pcm_buf_d;
      pcm_empty_q <= pcm_empty_d;
      dmc_int_q   <= dmc_int_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign RUNDMC     = (state_q != ST_IDLE);
  assign DMCRDY     = (state_q == ST_IDLE);
  assign n_DMCAB    = (state_q != ST_FETCH);
  assign DMC_Addr   = addr_q;
  assign PCM_Buf    = pcm_buf_q;
  assign PCM_Empty  = pcm_empty_q;
  assign DMC_Active = (remaining_q != 12'd0);
  assign DMC_INT    = dmc_int_q;

endmodule

// File: tb/tb_dmc_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmc_dma_ctrl
//
// Scoreboard bench for dmc_dma_ctrl. Whenever a sample is started the bench
// computes the full list of addresses it should read and queues them. A
// monitor pops one entry per DMA fetch, compares the bus address and then
// checks that the byte on DB during the fetch lands in PCM_Buf.
// ---------------------------------------------------------------------------
module tb_dmc_dma_ctrl;

  logic        ACLK = 1'b0;
  logic        RES = 1'b1;
  logic        W4010 = 1'b0;
  logic        W4012 = 1'b0;
  logic        W4013 = 1'b0;
  logic        W4015 = 1'b0;
  logic [7:0]  DB = 8'h00;
  logic        RnW = 1'b1;
  logic        PCM_Take = 1'b0;
  logic        RUNDMC;
  logic        n_DMCAB;
  logic        DMCRDY;
  logic [15:0] DMC_Addr;
  logic [7:0]  PCM_Buf;
  logic        PCM_Empty;
  logic        DMC_Active;
  logic        DMC_INT;

  dmc_dma_ctrl dut (
    .ACLK       (ACLK),
    .RES        (RES),
    .W4010      (W4010),
    .W4012      (W4012),
    .W4013      (W4013),
    .W4015      (W4015),
    .DB         (DB),
    .RnW        (RnW),
    .PCM_Take   (PCM_Take),
    .RUNDMC     (RUNDMC),
    .n_DMCAB    (n_DMCAB),
    .DMCRDY     (DMCRDY),
    .DMC_Addr   (DMC_Addr),
    .PCM_Buf    (PCM_Buf),
    .PCM_Empty  (PCM_Empty),
    .DMC_Active (DMC_Active),
    .DMC_INT    (DMC_INT)
  );

  always #5 ACLK = ~ACLK;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] addrQ[$];
  int          takeBudget = 0;
  bit          randBus = 1'b0;
  int          stallCnt = 0;
  int          lastStall = 0;
  int          nLow = 0;
  bit          checkBufNext = 1'b0;
  logic [7:0]  fetchedByte = 8'h00;

  // Single comparison point: every check bumps the vector count, and a
  // mismatch bumps the miscompare count and prints one line.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s_timeout: got no completion, required completion", name);
  endtask

  // One CPU cycle; in random mode the bus type and data wander every cycle.
  task automatic tick();
    @(posedge ACLK);
    #1;
    if (randBus) begin
      RnW = 1'($urandom_range(0, 1));
      DB  = 8'($urandom);
    end
  endtask

  // Register write: regSel 0 -> $4010, 2 -> $4012, 3 -> $4013, else $4015.
  task automatic applyStimulus(input int regSel, input logic [7:0] data);
    DB = data;
    case (regSel)
      0:       W4010 = 1'b1;
      2:       W4012 = 1'b1;
      3:       W4013 = 1'b1;
      default: W4015 = 1'b1;
    endcase
    @(posedge ACLK);
    #1;
    W4010 = 1'b0;
    W4012 = 1'b0;
    W4013 = 1'b0;
    W4015 = 1'b0;
  endtask

  // Reference model of a sample: start at $C000 + A*64, read L*16+1 bytes,
  // with the address rolling from $FFFF to $8000.
  task automatic pushSample(input logic [7:0] a, input logic [7:0] l);
    int addr;
    int count;
    addr  = 'hC000 + int'(a) * 64;
    count = int'(l) * 16 + 1;
    for (int i = 0; i < count; i++) begin
      addrQ.push_back(addr[15:0]);
      if (addr == 'hFFFF) addr = 'h8000;
      else addr = addr + 1;
    end
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!(DMC_Active === 1'b0 && DMCRDY === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) timeoutFail(name);
  endtask

  task automatic waitEmpty(input string name);
    int n = 0;
    while (PCM_Empty !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeoutFail(name);
  endtask

  task automatic waitHalt(input string name);
    int n = 0;
    while (DMCRDY !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeoutFail(name);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_RUNDMC"}, 16'(RUNDMC), 16'h0000);
    checkOutput({tag, "_n_DMCAB"}, 16'(n_DMCAB), 16'h0001);
    checkOutput({tag, "_DMCRDY"}, 16'(DMCRDY), 16'h0001);
    checkOutput({tag, "_DMC_Addr"}, DMC_Addr, 16'hC000);
    checkOutput({tag, "_PCM_Buf"}, 16'(PCM_Buf), 16'h0000);
    checkOutput({tag, "_PCM_Empty"}, 16'(PCM_Empty), 16'h0001);
    checkOutput({tag, "_DMC_Active"}, 16'(DMC_Active), 16'h0000);
    checkOutput({tag, "_DMC_INT"}, 16'(DMC_INT), 16'h0000);
  endtask

  // Output-unit stand-in: consumes a full buffer one cycle after it fills,
  // limited by takeBudget (negative means unlimited).
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (takeBudget != 0 && PCM_Empty === 1'b0 && !RES) begin
        PCM_Take = 1'b1;
        if (takeBudget > 0) takeBudget--;
      end else begin
        PCM_Take = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every fetch, checks the delivered byte
  // the cycle after, and checks that each stall holds exactly one bus cycle.
  always @(negedge ACLK) begin
    if (checkBufNext) begin
      if (!RES) begin
        checkOutput("fetch_data", 16'(PCM_Buf), 16'(fetchedByte));
        checkOutput("fetch_full", 16'(PCM_Empty), 16'h0000);
      end
      checkBufNext = 1'b0;
    end
    if (!RES && n_DMCAB === 1'b0) begin
      if (addrQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL fetch_unexpected: got addr %h, required no fetch", DMC_Addr);
      end else begin
        checkOutput("fetch_addr", DMC_Addr, addrQ.pop_front());
      end
      checkOutput("fetch_stall", 16'({DMCRDY, RUNDMC}), 16'h0001);
      fetchedByte  = DB;
      checkBufNext = 1'b1;
      nLow++;
    end
    if (DMCRDY === 1'b0) begin
      stallCnt++;
    end else if (stallCnt != 0) begin
      lastStall = stallCnt;
      checkOutput("bus_cycles_per_stall", 16'(nLow), 16'h0001);
      stallCnt = 0;
      nLow     = 0;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test, required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then randomized samples.
  initial begin
    logic [7:0] ra;
    logic [7:0] rl;
    logic       rirq;
    int         lowCount;

    RES = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    RES = 1'b0;
    checkResetValues("reset");

    // Single byte from A=1, L=0.
    $display("[TB] single byte fetch");
    takeBudget = 0;
    applyStimulus(2, 8'h01);
    applyStimulus(3, 8'h00);
    pushSample(8'h01, 8'h00);
    applyStimulus(5, 8'h10);
    DB = 8'hA5;
    waitDone("single", 50);
    checkOutput("single_buf", 16'(PCM_Buf), 16'h00A5);
    checkOutput("single_empty", 16'(PCM_Empty), 16'h0000);
    checkOutput("single_active", 16'(DMC_Active), 16'h0000);
    checkOutput("single_int", 16'(DMC_INT), 16'h0000);
    tick();
    checkOutput("single_stall", 16'(lastStall), 16'd3);

    // Write cycles during HALT stretch the stall.
    $display("[TB] write-cycle hold");
    takeBudget = -1;
    waitEmpty("hold_empty");
    RnW = 1'b0;
    pushSample(8'h01, 8'h00);
    applyStimulus(5, 8'h10);
    waitHalt("hold_halt");
    for (int k = 0; k < 3; k++) begin
      checkOutput("hold_rdy", 16'(DMCRDY), 16'h0000);
      checkOutput("hold_bus", 16'(n_DMCAB), 16'h0001);
      tick();
    end
    RnW = 1'b1;
    takeBudget = 0;
    waitDone("hold", 50);
    tick();
    checkOutput("hold_stall", 16'(lastStall), 16'd6);

    // Looping sample keeps fetching the same byte.
    $display("[TB] loop");
    applyStimulus(0, 8'h40);
    pushSample(8'h01, 8'h00);
    pushSample(8'h01, 8'h00);
    pushSample(8'h01, 8'h00);
    applyStimulus(5, 8'h10);
    takeBudget = 3;
    begin
      int n = 0;
      while (!(addrQ.size() == 0 && takeBudget == 0 && PCM_Empty === 1'b0
               && DMCRDY === 1'b1) && n < 300) begin
        tick();
        n++;
      end
      if (n >= 300) timeoutFail("loop");
    end
    repeat (10) tick();
    checkOutput("loop_active", 16'(DMC_Active), 16'h0001);
    checkOutput("loop_int", 16'(DMC_INT), 16'h0000);
    checkOutput("loop_addr", DMC_Addr, 16'hC040);
    applyStimulus(0, 8'h00);
    pushSample(8'h01, 8'h00);
    takeBudget = -1;
    waitDone("loop_end", 100);
    checkOutput("loop_end_active", 16'(DMC_Active), 16'h0000);
    checkOutput("loop_end_int", 16'(DMC_INT), 16'h0000);

    // IRQ at a non-looping sample end, cleared by a $4015 write.
    $display("[TB] irq");
    applyStimulus(0, 8'h80);
    pushSample(8'h01, 8'h00);
    applyStimulus(5, 8'h10);
    waitDone("irq", 100);
    checkOutput("irq_set", 16'(DMC_INT), 16'h0001);
    applyStimulus(5, 8'h00);
    checkOutput("irq_clear", 16'(DMC_INT), 16'h0000);

    // Disable written during ALIGN: the fetch completes, nothing follows.
    $display("[TB] disable mid-DMA");
    waitEmpty("dis_empty");
    takeBudget = 0;
    applyStimulus(3, 8'h01);
    addrQ.push_back(16'hC040);
    applyStimulus(5, 8'h10);
    waitHalt("dis_halt");
    tick();
    checkOutput("dis_align", 16'({DMCRDY, n_DMCAB}), 16'h0001);
    applyStimulus(5, 8'h00);
    checkOutput("dis_fetch", 16'(n_DMCAB), 16'h0000);
    DB = 8'h3C;
    waitDone("dis", 50);
    checkOutput("dis_buf", 16'(PCM_Buf), 16'h003C);
    checkOutput("dis_active", 16'(DMC_Active), 16'h0000);
    checkOutput("dis_int", 16'(DMC_INT), 16'h0000);
    takeBudget = -1;
    lowCount = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (DMCRDY !== 1'b1) lowCount++;
    end
    checkOutput("dis_no_halt", 16'(lowCount), 16'h0000);
    checkOutput("dis_taken", 16'(PCM_Empty), 16'h0001);

    // Address wrap: 65 bytes from $FFC0, the last one at $8000.
    $display("[TB] address wrap");
    applyStimulus(0, 8'h00);
    applyStimulus(2, 8'hFF);
    applyStimulus(3, 8'h04);
    pushSample(8'hFF, 8'h04);
    applyStimulus(5, 8'h10);
    waitDone("wrap", 3000);
    checkOutput("wrap_left", 16'(addrQ.size()), 16'h0000);
    checkOutput("wrap_addr", DMC_Addr, 16'h8001);
    checkOutput("wrap_active", 16'(DMC_Active), 16'h0000);

    // Reset held for two cycles starting mid-FETCH.
    $display("[TB] reset mid-DMA");
    applyStimulus(2, 8'h02);
    applyStimulus(3, 8'h03);
    waitEmpty("rst_empty");
    addrQ.push_back(16'hC080);
    applyStimulus(5, 8'h10);
    begin
      int n = 0;
      while (n_DMCAB !== 1'b0 && n < 50) begin
        @(negedge ACLK);
        n++;
      end
      if (n >= 50) timeoutFail("rst_fetch");
    end
    #1;
    RES = 1'b1;
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    RES = 1'b0;
    checkResetValues("midreset");
    checkOutput("midreset_queue", 16'(addrQ.size()), 16'h0000);
    // A and L were cleared too, so an enable fetches one byte at $C000.
    pushSample(8'h00, 8'h00);
    applyStimulus(5, 8'h10);
    waitDone("post_reset", 50);
    tick();
    checkOutput("post_reset_queue", 16'(addrQ.size()), 16'h0000);

    // Randomized samples with wandering bus traffic.
    $display("[TB] random samples");
    randBus = 1'b1;
    for (int it = 0; it < 6; it++) begin
      ra   = 8'($urandom);
      rl   = 8'($urandom_range(0, 2));
      rirq = 1'($urandom_range(0, 1));
      applyStimulus(0, {rirq, 7'b0000000});
      applyStimulus(2, ra);
      applyStimulus(3, rl);
      pushSample(ra, rl);
      applyStimulus(5, 8'h10);
      waitDone("rand", 4000);
      checkOutput("rand_int", 16'(DMC_INT), 16'(rirq));
      checkOutput("rand_left", 16'(addrQ.size()), 16'h0000);
      applyStimulus(5, 8'h00);
      checkOutput("rand_int_clear", 16'(DMC_INT), 16'h0000);
    end
    randBus = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmc_dma_ctrl.md
# dmc_dma_ctrl

Delta-modulation channel DMA controller for the APU. It holds the DMC sample address and length state and a one-byte sample buffer for the DMC output unit. When the buffer empties and bytes remain, it runs a one-byte DMA fetch. It sits directly upstream of the sprite DMA / address-mux stage and drives that stage's RUNDMC, n_DMCAB, DMCRDY and DMC_Addr inputs.

## Interface
Parameters: none.
- ACLK  in  1  clock; one rising edge per CPU cycle
- RES  in  1  reset, synchronous, active-high
- W4010, W4012, W4013, W4015  in  1  register write strobes, one cycle wide
- DB  in  8  CPU data bus; register write data, and the DMA read data during FETCH
- RnW  in  1  CPU cycle type; 1 = read cycle
- PCM_Take  in  1  output unit consumed the buffer (one-cycle pulse)
- RUNDMC  out  1  DMC DMA in progress; holds sprite DMA in standby
- n_DMCAB  out  1  0 = DMC owns the address bus this cycle
- DMCRDY  out  1  0 = stall the CPU (ANDed into RDY downstream)
- DMC_Addr  out  16  sample address counter
- PCM_Buf  out  8  sample buffer
- PCM_Empty  out  1  sample buffer empty
- DMC_Active  out  1  bytes remaining != 0 ($4015 status bit 4)
- DMC_INT  out  1  DMC interrupt flag

## Operation
Registers:
- $4010: bit7 irq_en, bit6 loop. Writing with bit7=0 clears DMC_INT.
- $4012: A[7:0]. Start address = 16'hC000 + A*64.
- $4013: L[7:0]. Length = L*16 + 1 (12-bit remaining counter).
- $4015: bit4=0 sets remaining to 0. bit4=1 with remaining==0 reloads the address counter and remaining from A/L. bit4=1 with remaining!=0 has no effect. Any $4015 write clears DMC_INT.
- $4012/$4013 writes do not disturb a running sample; they take effect at the next reload.

Address counter:
- Increments by 1 after each fetch.
- 16'hFFFF wraps to 16'h8000, never 16'h0000.

Sample buffer:
- PCM_Take while PCM_Empty=0 sets PCM_Empty=1. PCM_Buf keeps its value.
- PCM_Take while PCM_Empty=1 is ignored.

State machine IDLE → HALT → ALIGN → FETCH → IDLE:
- IDLE: go to HALT when PCM_Empty=1 and remaining!=0.
- HALT: DMCRDY=0 and RUNDMC=1. Stay while RnW=0, because the CPU ignores RDY on write cycles. Go to ALIGN on the first cycle with RnW=1.
- ALIGN: one dummy cycle; DMCRDY=0, RUNDMC=1.
- FETCH: n_DMCAB=0, DMC_Addr drives the bus, DMCRDY=0, RUNDMC=1. At the ACLK edge ending FETCH:
  - PCM_Buf ← DB and PCM_Empty ← 0.
  - The address counter increments and remaining decrements.
- End-of-sample, when remaining goes 1→0:
  - loop=1: reload address and remaining from A/L.
  - loop=0 and irq_en=1: set DMC_INT.
  - loop=0 and irq_en=0: no action.

Boundary cases:
- $4015 disable during HALT/ALIGN/FETCH: the DMA completes and the byte is delivered. remaining is forced to 0 (the decrement is suppressed). No IRQ and no loop reload.
- $4015 enable in the same cycle as a fetch edge that ends the sample: the reload wins, and DMC_INT is not set.
- PCM_Take is ignored during FETCH's edge, because the buffer is empty by construction.
- RES at any time, including mid-DMA: return to IDLE and apply the reset values below on the next edge.

## Timing
Reset values:
- RUNDMC=0, n_DMCAB=1, DMCRDY=1.
- DMC_Addr=16'hC000, PCM_Buf=8'h00, PCM_Empty=1.
- DMC_Active=0, DMC_INT=0.
- irq_en=0, loop=0, A=0, L=0, remaining=0.

Cycle-level behaviour:
- All outputs are registered or decoded from the state and registers only; no DB→output combinational path.
- Write strobes are sampled at the ACLK edge; a register's new value is visible the next cycle.
- Request to HALT: the cycle after the IDLE condition is met, e.g. the cycle after the enabling $4015 write.
- Minimum stall with RnW=1 throughout is 3 cycles of DMCRDY=0 (HALT, ALIGN, FETCH); each RnW=0 cycle in HALT adds 1.
- n_DMCAB is low for exactly one cycle per byte.
- PCM_Buf, PCM_Empty, DMC_Active and DMC_INT update at the edge ending FETCH.
- Back-to-back: with PCM_Take arriving in the cycle after FETCH, the next HALT begins the cycle after that.

## Test plan
- Reset: apply RES=1 for 2 cycles mid-FETCH → all outputs at their reset values next cycle; DMC_Addr=$C000, PCM_Empty=1.
- Single byte fetch:
  - Stimulus: W4012=$01, W4013=$00, W4015=$10, RnW=1, DB=$A5 during FETCH.
  - Required: DMCRDY low for 3 cycles; n_DMCAB low with DMC_Addr=$C040; then PCM_Buf=$A5, PCM_Empty=0, DMC_Active=0, DMC_INT=0.
- Write-cycle hold: RnW=0 for 3 cycles after HALT is entered → DMCRDY=0 and n_DMCAB=1 for all 3 cycles; ALIGN follows the first RnW=1 cycle; 6 stall cycles total.
- Address wrap:
  - Stimulus: A=$FF, L=$04 (65 bytes), PCM_Take after each byte.
  - Required: fetch addresses $FFC0..$FFFF, then $8000 for the 65th byte; DMC_Active drops after byte 65.
- IRQ and loop:
  - $4010=$80, L=0, one byte → DMC_INT=1; a following $4015 write clears it.
  - $4010=$40 → after the byte, DMC_Active stays 1, the next fetch address is $C040, and DMC_INT stays 0.
- Disable mid-DMA: W4015=$00 during ALIGN → FETCH still occurs and PCM_Buf is loaded; DMC_Active=0; no further HALT after PCM_Take; DMC_INT=0.
